difftest_commit_fifo: RTL

//   Receive end of the WB-stage difftest commit stream. Buffers commit records
//   {pc, instr, nextpc} issued by the core when a WB instruction retires, and

---
 rtl/difftest_commit_fifo.sv | 108 ++++++++++
 1 files changed

// File: rtl/difftest_commit_fifo.sv
// Difftest commit buffer: queues {pc, instr, nextpc} records retired in WB and
// drains them first-word-fall-through to the checker, with error monitoring.
module difftest_commit_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic [DATA_WIDTH-1:0] in_nextpc,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0] out_nextpc,
    output logic [63:0]           commit_cnt,
    output logic                  overflow_err,
    output logic                  timeout_err,
    input  logic                  err_clr
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int RW  = 3 * DATA_WIDTH;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    logic [RW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [63:0]    commit_cnt_q, commit_cnt_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           overflow_q, overflow_d;
    logic           timeout_q, timeout_d;

    logic empty, full, push, pop;
    logic [RW-1:0] head_rec;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign in_ready  = !full || out_ready;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head_rec   = mem_q[rd_ptr_q[AW-1:0]];
    assign out_pc     = head_rec[RW-1 -: DATA_WIDTH];
    assign out_instr  = head_rec[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_nextpc = head_rec[DATA_WIDTH-1:0];

    assign commit_cnt   = commit_cnt_q;
    assign overflow_err = overflow_q;
    assign timeout_err  = timeout_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        commit_cnt_d = commit_cnt_q;
        wdog_d       = wdog_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            commit_cnt_d = commit_cnt_q + 64'd1;
        end
        if (push || err_clr) begin
            wdog_d = '0;
        end else if (wdog_q != WD_LIMIT) begin
            wdog_d = wdog_q + WDW'(1);
        end
        // Sticky flags: a new error event outranks a simultaneous clear.
        overflow_d = (overflow_q && !err_clr) || (in_valid && !in_ready);
        timeout_d  = (timeout_q && !err_clr) || (wdog_d == WD_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            commit_cnt_q <= '0;
            wdog_q       <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            commit_cnt_q <= commit_cnt_d;
            wdog_q       <= wdog_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    // Record storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_pc, in_instr, in_nextpc};
        end
    end

endmodule
